sim_end_controller: RTL and testbench

Parametrised end-of-simulation controller for the pipelined RISC-V testbench top. It watches several halt sources and applies a configurable drain delay. On a clean finish it streams the compliance signature region out of the RAM model over a request/acknowledge read port. It then reports a latched exit code and end reason, and can optionally enforce a retirement watchdog. The testbench top converts `done_o`/`exit_code_o` into `$finish` and writes streamed words to the `.sig` file.

---
 rtl/sim_end_pkg.sv | 35 +++
 rtl/sim_end_controller_if.sv | 27 ++
 rtl/sim_end_watchdog.sv | 29 ++
 rtl/sim_end_controller.sv | 182 ++++++++++++++++++
 tb/tb_sim_end_controller.sv | 348 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sim_end_pkg.sv
// Shared types and constants for the end-of-simulation controller.
// RAM_BEGIN_ADDR normally comes from the testbench build; a fallback is
// provided so the block elaborates stand-alone.
`ifndef RAM_BEGIN_ADDR
`define RAM_BEGIN_ADDR 32'h8000_0000
`endif

package sim_end_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_RD_REQ,
        ST_RD_OUT,
        ST_DONE
    } state_t;

    localparam logic [7:0] EXIT_PASS  = 8'd0;
    localparam logic [7:0] EXIT_TRAP  = 8'd1;
    localparam logic [7:0] EXIT_BREAK = 8'd2;
    localparam logic [7:0] EXIT_WDOG  = 8'd3;

    localparam logic [2:0] REASON_NONE       = 3'd0;
    localparam logic [2:0] REASON_PASS_SIG   = 3'd1;
    localparam logic [2:0] REASON_PASS_NOSIG = 3'd2;
    localparam logic [2:0] REASON_BREAK      = 3'd3;
    localparam logic [2:0] REASON_TRAP       = 3'd4;
    localparam logic [2:0] REASON_WDOG       = 3'd5;

    // mcause one-hot bit that marks an ebreak
    localparam int BRK_BIT = 3;

    localparam int SIG_WORD_BYTES = 4;

endpackage

// File: rtl/sim_end_controller_if.sv
// Bus bundle of the end controller: RAM-model read port (req/ack) and the
// signature word stream (valid/ready). master = controller side.
interface sim_end_controller_if #(
    parameter int ADDR_W = 32
);
    logic              mem_req_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_ack_i;
    logic [31:0]       mem_data_i;
    logic              sig_valid_o;
    logic [31:0]       sig_data_o;
    logic              sig_ready_i;

    modport master (
        output mem_req_o, mem_addr_o,
        input  mem_ack_i, mem_data_i,
        output sig_valid_o, sig_data_o,
        input  sig_ready_i
    );

    modport slave (
        input  mem_req_o, mem_addr_o,
        output mem_ack_i, mem_data_i,
        input  sig_valid_o, sig_data_o,
        output sig_ready_i
    );
endinterface

// File: rtl/sim_end_watchdog.sv
// Retirement watchdog: counts idle cycles while enabled, restarts on every
// retired instruction, and flags the edge on which LIMIT idle cycles are reached.
module sim_end_watchdog #(
    parameter logic [31:0] WDOG_LIMIT = 32'd1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic hit
);
    // hit fires while the counter holds LIMIT-1 so the end lands on edge LIMIT
    localparam logic [31:0] LAST = (WDOG_LIMIT == 32'd0) ? 32'd0 : WDOG_LIMIT - 32'd1;

    logic [31:0] idle_cnt;

    // idle-cycle counter, saturating at LAST
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (clr || !en) begin
            idle_cnt <= '0;
        end else if (idle_cnt != LAST) begin
            idle_cnt <= idle_cnt + 32'd1;
        end
    end

    assign hit = en && !clr && (idle_cnt == LAST);
endmodule

// File: rtl/sim_end_controller.sv
// End-of-simulation controller: halt arbitration, drain delay, signature
// streaming from the RAM model and latched exit code / end reason.
// Optional feature macro: SIM_END_WATCHDOG_EN (retirement watchdog).
module sim_end_controller
    import sim_end_pkg::*;
#(
    parameter int                NUM_SRC      = 2,
    parameter int                DRAIN_CYCLES = 4,
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RAM_BASE     = `RAM_BEGIN_ADDR,
    parameter logic [31:0]       WDOG_LIMIT   = 32'd1_000_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_SRC-1:0]    halt_i,
    input  logic [NUM_SRC-1:0]    loop_i,
    input  logic [32*NUM_SRC-1:0] mcause_i,
    input  logic [ADDR_W-1:0]     sig_begin_i,
    input  logic [ADDR_W-1:0]     sig_end_i,
    input  logic                  instret_i,
    sim_end_controller_if.master  bus,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [7:0]            exit_code_o,
    output logic [2:0]            reason_o,
    output logic [ADDR_W-1:0]     sig_count_o
);
    localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;
    localparam logic [DCW-1:0]    DRAIN_LOAD = DCW'(DRAIN_CYCLES);
    localparam logic [ADDR_W-1:0] WORD_STEP  = ADDR_W'(SIG_WORD_BYTES);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(WORD_STEP - 1'b1);

    state_t            state;
    logic [DCW-1:0]    drain_cnt;
    logic              lat_loop;
    logic              lat_brk;
    logic [ADDR_W-1:0] sig_begin_q;
    logic [ADDR_W-1:0] sig_end_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_next;
    logic              mem_req_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              sig_valid_q;
    logic [31:0]       sig_data_q;

    logic              halt_any;
    logic              sel_loop;
    logic              sel_brk;
    logic              wdog_hit;

    // lowest-index halting source wins: scan downward so index 0 is written last
    always_comb begin
        halt_any = |halt_i;
        sel_loop = 1'b0;
        sel_brk  = 1'b0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (halt_i[i]) begin
                sel_loop = loop_i[i];
                sel_brk  = mcause_i[32*i + BRK_BIT];
            end
        end
    end

    assign addr_next = addr_q + WORD_STEP;

`ifdef SIM_END_WATCHDOG_EN
    sim_end_watchdog #(
        .WDOG_LIMIT (WDOG_LIMIT)
    ) u_wdog (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state == ST_IDLE),
        .clr   (instret_i),
        .hit   (wdog_hit)
    );
`else
    assign wdog_hit = 1'b0;
`endif

    // main sequencer: all outputs registered, asynchronous abort on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            drain_cnt   <= '0;
            lat_loop    <= 1'b0;
            lat_brk     <= 1'b0;
            sig_begin_q <= '0;
            sig_end_q   <= '0;
            addr_q      <= '0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            sig_valid_q <= 1'b0;
            sig_data_q  <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            exit_code_o <= EXIT_PASS;
            reason_o    <= REASON_NONE;
            sig_count_o <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // a halt in the same cycle takes precedence over the watchdog
                    if (halt_any) begin
                        lat_loop    <= sel_loop;
                        lat_brk     <= sel_brk;
                        sig_begin_q <= sig_begin_i & ALIGN_MASK;
                        sig_end_q   <= sig_end_i & ALIGN_MASK;
                        drain_cnt   <= DRAIN_LOAD;
                        busy_o      <= 1'b1;
                        state       <= ST_DRAIN;
                    end else if (wdog_hit) begin
                        done_o      <= 1'b1;
                        exit_code_o <= EXIT_WDOG;
                        reason_o    <= REASON_WDOG;
                        state       <= ST_DONE;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt != '0) begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end else if (lat_loop && (sig_end_q > sig_begin_q)) begin
                        addr_q     <= sig_begin_q;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= sig_begin_q - RAM_BASE;
                        reason_o   <= REASON_PASS_SIG;
                        state      <= ST_RD_REQ;
                    end else begin
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                        state  <= ST_DONE;
                        if (lat_loop) begin
                            exit_code_o <= EXIT_PASS;
                            reason_o    <= REASON_PASS_NOSIG;
                        end else if (lat_brk) begin
                            exit_code_o <= EXIT_BREAK;
                            reason_o    <= REASON_BREAK;
                        end else begin
                            exit_code_o <= EXIT_TRAP;
                            reason_o    <= REASON_TRAP;
                        end
                    end
                end
                ST_RD_REQ: begin
                    if (bus.mem_ack_i) begin
                        mem_req_q   <= 1'b0;
                        sig_valid_q <= 1'b1;
                        sig_data_q  <= bus.mem_data_i;
                        state       <= ST_RD_OUT;
                    end
                end
                ST_RD_OUT: begin
                    if (bus.sig_ready_i) begin
                        sig_valid_q <= 1'b0;
                        addr_q      <= addr_next;
                        sig_count_o <= sig_count_o + 1'b1;
                        if (addr_next >= sig_end_q) begin
                            busy_o      <= 1'b0;
                            done_o      <= 1'b1;
                            exit_code_o <= EXIT_PASS;
                            state       <= ST_DONE;
                        end else begin
                            mem_req_q  <= 1'b1;
                            mem_addr_q <= addr_next - RAM_BASE;
                            state      <= ST_RD_REQ;
                        end
                    end
                end
                ST_DONE: begin
                    // terminal until reset; later halts are ignored
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_req_o   = mem_req_q;
    assign bus.mem_addr_o  = mem_addr_q;
    assign bus.sig_valid_o = sig_valid_q;
    assign bus.sig_data_o  = sig_data_q;
endmodule

// File: tb/tb_sim_end_controller.sv
// Directed bench for sim_end_controller (DRAIN_CYCLES=4 and 0 instances,
// plus a WDOG_LIMIT=16 instance when SIM_END_WATCHDOG_EN is defined).
`timescale 1ns/1ps
module tb_sim_end_controller;
    localparam logic [31:0] BASE = 32'h8000_0000;

    logic        clk;
    logic        rst_n;
    logic [1:0]  halt, loop;
    logic [63:0] mcause;
    logic [31:0] sb, se;
    logic        instret;
    logic        busy, done;
    logic [7:0]  exitc;
    logic [2:0]  reason;
    logic [31:0] count;

    logic [1:0]  halt0, loop0;
    logic [63:0] mcause0;
    logic        busy0, done0;
    logic [7:0]  exitc0;
    logic [2:0]  reason0;
    logic [31:0] count0;

    int checks = 0;
    int errors = 0;

    sim_end_controller_if #(.ADDR_W(32)) ifa ();
    sim_end_controller_if #(.ADDR_W(32)) ifb ();

    sim_end_controller #(
        .NUM_SRC(2), .DRAIN_CYCLES(4), .ADDR_W(32), .RAM_BASE(BASE), .WDOG_LIMIT(32'd1_000_000)
    ) dut (
        .clk(clk), .rst_n(rst_n), .halt_i(halt), .loop_i(loop), .mcause_i(mcause),
        .sig_begin_i(sb), .sig_end_i(se), .instret_i(instret), .bus(ifa),
        .busy_o(busy), .done_o(done), .exit_code_o(exitc), .reason_o(reason), .sig_count_o(count)
    );

    sim_end_controller #(
        .NUM_SRC(2), .DRAIN_CYCLES(0), .ADDR_W(32), .RAM_BASE(BASE), .WDOG_LIMIT(32'd1_000_000)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .halt_i(halt0), .loop_i(loop0), .mcause_i(mcause0),
        .sig_begin_i(sb), .sig_end_i(se), .instret_i(instret), .bus(ifb),
        .busy_o(busy0), .done_o(done0), .exit_code_o(exitc0), .reason_o(reason0), .sig_count_o(count0)
    );

`ifdef SIM_END_WATCHDOG_EN
    logic        busyw, donew;
    logic [7:0]  exitw;
    logic [2:0]  reasonw;
    logic [31:0] countw;
    sim_end_controller_if #(.ADDR_W(32)) ifw ();
    sim_end_controller #(
        .NUM_SRC(2), .DRAIN_CYCLES(4), .ADDR_W(32), .RAM_BASE(BASE), .WDOG_LIMIT(32'd16)
    ) dutw (
        .clk(clk), .rst_n(rst_n), .halt_i(halt), .loop_i(loop), .mcause_i(mcause),
        .sig_begin_i(sb), .sig_end_i(se), .instret_i(instret), .bus(ifw),
        .busy_o(busyw), .done_o(donew), .exit_code_o(exitw), .reason_o(reasonw), .sig_count_o(countw)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        halt = '0; loop = '0; mcause = '0;
        halt0 = '0; loop0 = '0; mcause0 = '0;
        sb = '0; se = '0; instret = 1'b0;
        ifa.mem_ack_i = 1'b0; ifa.mem_data_i = '0; ifa.sig_ready_i = 1'b0;
        ifb.mem_ack_i = 1'b0; ifb.mem_data_i = '0; ifb.sig_ready_i = 1'b0;
`ifdef SIM_END_WATCHDOG_EN
        ifw.mem_ack_i = 1'b0; ifw.mem_data_i = '0; ifw.sig_ready_i = 1'b0;
`endif
    endtask

    // reset for two edges; release 1ns after an edge so the next edge is cycle 1
    task automatic do_reset();
        tick();
        rst_n = 1'b0;
        clear_inputs();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({busy, done, exitc, reason} !== 13'd0) begin
            errors++; $display("FAIL reset_status got %b want 0", {busy, done, exitc, reason});
        end
        checks++;
        if ({ifa.mem_req_o, ifa.sig_valid_o} !== 2'b00 || count !== 32'd0) begin
            errors++; $display("FAIL reset_bus got req=%b valid=%b count=%0d want 0", ifa.mem_req_o, ifa.sig_valid_o, count);
        end
    endtask

    task automatic test_priority();
        int early;
        do_reset();
        halt = 2'b11; loop = 2'b10; mcause = {32'h0, 32'h8};
        tick();
        halt = '0; loop = '0; mcause = '0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL prio_drain got busy=%b done=%b want 1 0", busy, done);
        end
        early = 0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            if (done !== 1'b0) early = 1;
        end
        checks++;
        if (early != 0) begin
            errors++; $display("FAIL prio_early got done before edge T+5 want none");
        end
        tick();
        checks++;
        if (done !== 1'b1 || exitc !== 8'd2 || reason !== 3'd3 || busy !== 1'b0) begin
            errors++; $display("FAIL prio_end got done=%b exit=%0d reason=%0d busy=%b want 1 2 3 0", done, exitc, reason, busy);
        end
        halt = 2'b01; loop = 2'b01;
        tick(); tick();
        halt = '0; loop = '0;
        checks++;
        if (done !== 1'b1 || exitc !== 8'd2 || ifa.mem_req_o !== 1'b0) begin
            errors++; $display("FAIL prio_hold got done=%b exit=%0d req=%b want 1 2 0", done, exitc, ifa.mem_req_o);
        end
    endtask

    task automatic test_signature();
        logic [31:0] ea, pat;
        do_reset();
        sb = BASE + 32'h100; se = BASE + 32'h110; halt = 2'b01; loop = 2'b01;
        tick();
        halt = '0; loop = '0;
        repeat (4) tick();
        checks++;
        if (ifa.mem_req_o !== 1'b0) begin
            errors++; $display("FAIL sig_req_early got %b want 0", ifa.mem_req_o);
        end
        tick();
        checks++;
        if (reason !== 3'd1 || busy !== 1'b1) begin
            errors++; $display("FAIL sig_reason got reason=%0d busy=%b want 1 1", reason, busy);
        end
        for (int w = 0; w < 4; w++) begin
            ea  = 32'h100 + 32'(4 * w);
            pat = 32'hC0DE_0000 + 32'(w * 17);
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (ifa.mem_req_o !== 1'b1 || ifa.mem_addr_o !== ea) begin
                    errors++; $display("FAIL sig_req w%0d k%0d got req=%b addr=%h want 1 %h", w, k, ifa.mem_req_o, ifa.mem_addr_o, ea);
                end
                if (k == 2) begin
                    ifa.mem_ack_i = 1'b1; ifa.mem_data_i = pat;
                end
                tick();
            end
            ifa.mem_ack_i = 1'b0; ifa.mem_data_i = 32'hDEAD_BEEF;
            checks++;
            if (ifa.mem_req_o !== 1'b0 || ifa.sig_valid_o !== 1'b1 || ifa.sig_data_o !== pat) begin
                errors++; $display("FAIL sig_out w%0d got req=%b valid=%b data=%h want 0 1 %h", w, ifa.mem_req_o, ifa.sig_valid_o, ifa.sig_data_o, pat);
            end
            tick();
            checks++;
            if (ifa.sig_valid_o !== 1'b1 || ifa.sig_data_o !== pat) begin
                errors++; $display("FAIL sig_stall w%0d got valid=%b data=%h want 1 %h", w, ifa.sig_valid_o, ifa.sig_data_o, pat);
            end
            ifa.sig_ready_i = 1'b1;
            tick();
            ifa.sig_ready_i = 1'b0;
            checks++;
            if (ifa.sig_valid_o !== 1'b0 || count !== 32'(w + 1)) begin
                errors++; $display("FAIL sig_hs w%0d got valid=%b count=%0d want 0 %0d", w, ifa.sig_valid_o, count, w + 1);
            end
        end
        checks++;
        if (done !== 1'b1 || exitc !== 8'd0 || reason !== 3'd1 || count !== 32'd4) begin
            errors++; $display("FAIL sig_end got done=%b exit=%0d reason=%0d count=%0d want 1 0 1 4", done, exitc, reason, count);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] pat;
        do_reset();
        sb = BASE + 32'h203; se = BASE + 32'h20B; halt = 2'b01; loop = 2'b01;
        tick();
        halt = '0; loop = '0;
        repeat (5) tick();
        for (int w = 0; w < 2; w++) begin
            pat = 32'h5A00_0001 << w;
            checks++;
            if (ifa.mem_req_o !== 1'b1 || ifa.mem_addr_o !== 32'h200 + 32'(4 * w)) begin
                errors++; $display("FAIL b2b_req w%0d got req=%b addr=%h want 1 %h", w, ifa.mem_req_o, ifa.mem_addr_o, 32'h200 + 32'(4 * w));
            end
            ifa.mem_ack_i = 1'b1; ifa.mem_data_i = pat;
            tick();
            ifa.mem_ack_i = 1'b0;
            checks++;
            if (ifa.mem_req_o !== 1'b0 || ifa.sig_valid_o !== 1'b1 || ifa.sig_data_o !== pat) begin
                errors++; $display("FAIL b2b_out w%0d got req=%b valid=%b data=%h want 0 1 %h", w, ifa.mem_req_o, ifa.sig_valid_o, ifa.sig_data_o, pat);
            end
            ifa.sig_ready_i = 1'b1;
            tick();
            ifa.sig_ready_i = 1'b0;
        end
        checks++;
        if (done !== 1'b1 || exitc !== 8'd0 || count !== 32'd2 || ifa.mem_req_o !== 1'b0) begin
            errors++; $display("FAIL b2b_end got done=%b exit=%0d count=%0d req=%b want 1 0 2 0", done, exitc, count, ifa.mem_req_o);
        end
    endtask

    task automatic test_nosig();
        int seen_req;
        do_reset();
        sb = BASE + 32'h40; se = BASE + 32'h40; halt = 2'b01; loop = 2'b01;
        tick();
        halt = '0; loop = '0;
        seen_req = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (ifa.mem_req_o !== 1'b0) seen_req = 1;
        end
        checks++;
        if (seen_req != 0) begin
            errors++; $display("FAIL nosig_req got mem_req high want never");
        end
        checks++;
        if (done !== 1'b1 || exitc !== 8'd0 || reason !== 3'd2 || count !== 32'd0) begin
            errors++; $display("FAIL nosig_end got done=%b exit=%0d reason=%0d count=%0d want 1 0 2 0", done, exitc, reason, count);
        end
    endtask

    task automatic test_trap_drain0();
        do_reset();
        halt0 = 2'b01; loop0 = 2'b00; mcause0 = {32'h0, 32'h4};
        tick();
        halt0 = '0; mcause0 = '0;
        checks++;
        if (busy0 !== 1'b1 || done0 !== 1'b0) begin
            errors++; $display("FAIL trap0_drain got busy=%b done=%b want 1 0", busy0, done0);
        end
        tick();
        checks++;
        if (done0 !== 1'b1 || exitc0 !== 8'd1 || reason0 !== 3'd4) begin
            errors++; $display("FAIL trap0_end got done=%b exit=%0d reason=%0d want 1 1 4", done0, exitc0, reason0);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        sb = BASE + 32'h300; se = BASE + 32'h310; halt = 2'b01; loop = 2'b01;
        tick();
        halt = '0; loop = '0;
        repeat (5) tick();
        ifa.mem_ack_i = 1'b1; ifa.mem_data_i = 32'h1111_2222;
        tick();
        ifa.mem_ack_i = 1'b0;
        checks++;
        if (ifa.sig_valid_o !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL rstmid_setup got valid=%b busy=%b want 1 1", ifa.sig_valid_o, busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ifa.sig_valid_o, ifa.mem_req_o, done, busy} !== 4'b0000 || count !== 32'd0) begin
            errors++; $display("FAIL rstmid_abort got valid=%b req=%b done=%b busy=%b count=%0d want 0", ifa.sig_valid_o, ifa.mem_req_o, done, busy, count);
        end
        tick();
        rst_n = 1'b1;
        halt = 2'b10; loop = 2'b00; mcause = {32'h4, 32'h0};
        tick();
        halt = '0; mcause = '0;
        repeat (5) tick();
        checks++;
        if (done !== 1'b1 || exitc !== 8'd1 || reason !== 3'd4 || ifa.mem_req_o !== 1'b0) begin
            errors++; $display("FAIL rstmid_restart got done=%b exit=%0d reason=%0d req=%b want 1 1 4 0", done, exitc, reason, ifa.mem_req_o);
        end
    endtask

`ifdef SIM_END_WATCHDOG_EN
    task automatic test_watchdog();
        int early;
        do_reset();
        early = 0;
        for (int c = 1; c <= 15; c++) begin
            tick();
            if (donew !== 1'b0) early = 1;
        end
        checks++;
        if (early != 0) begin
            errors++; $display("FAIL wdog_early got done before cycle 16 want none");
        end
        tick();
        checks++;
        if (donew !== 1'b1 || exitw !== 8'd3 || reasonw !== 3'd5) begin
            errors++; $display("FAIL wdog_end got done=%b exit=%0d reason=%0d want 1 3 5", donew, exitw, reasonw);
        end
        do_reset();
        early = 0;
        for (int c = 1; c <= 25; c++) begin
            instret = (c == 10);
            tick();
            instret = 1'b0;
            if (donew !== 1'b0) early = 1;
        end
        checks++;
        if (early != 0) begin
            errors++; $display("FAIL wdog_pulse_early got done before cycle 26 want none");
        end
        tick();
        checks++;
        if (donew !== 1'b1 || exitw !== 8'd3) begin
            errors++; $display("FAIL wdog_pulse_end got done=%b exit=%0d want 1 3", donew, exitw);
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got no finish want finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        test_reset();
        test_priority();
        test_signature();
        test_back_to_back();
        test_nosig();
        test_trap_drain0();
        test_reset_mid();
`ifdef SIM_END_WATCHDOG_EN
        test_watchdog();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
